// File: rtl/taiga_types_pkg.sv
// Shared types and default configuration for the writeback commit path.
package taiga_types;

  localparam int unsigned CFG_NUM_UNITS    = 5;
  localparam int unsigned CFG_COMMIT_PORTS = 3;
  localparam int unsigned CFG_READ_PORTS   = 2;
  localparam int unsigned CFG_XLEN         = 32;
  localparam int unsigned CFG_ID_W         = 3;

  localparam int unsigned LOG2_COMMIT_PORTS = $clog2(CFG_COMMIT_PORTS);
  localparam int unsigned WB_UNITS_WIDTH    = $clog2(CFG_NUM_UNITS);

  typedef logic [CFG_ID_W-1:0] id_t;

  typedef struct packed {
    logic                valid;
    id_t                 id;
    logic [CFG_XLEN-1:0] data;
  } commit_packet_t;

endpackage

// File: rtl/commit_lvt.sv
// Live-value table: records which register-file bank holds the newest value of each register.
module commit_lvt
  import taiga_types::*;
#(
  parameter int unsigned WRITE_PORTS = CFG_COMMIT_PORTS,
  parameter int unsigned READ_PORTS  = CFG_READ_PORTS,
  localparam int unsigned BANK_W     = $clog2(WRITE_PORTS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WRITE_PORTS-1:0]              we,
  input  logic [WRITE_PORTS-1:0][4:0]         waddr,
  input  logic [READ_PORTS-1:0][4:0]          raddr,
  output logic [READ_PORTS-1:0][BANK_W-1:0]   rdata
);

  logic [31:0][BANK_W-1:0] lvt;

  // Writers never collide on an entry, so loop order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvt <= '0;
    end else begin
      for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
        if (we[i]) lvt[waddr[i]] <= BANK_W'(i);
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned r = 0; r < READ_PORTS; r++) rdata[r] = lvt[raddr[r]];
  end

endmodule

// File: rtl/writeback_commit_arbiter.sv
// Assigns completing units to register-file commit ports with rotating priority,
// drives bank write enables / LVT, and captures forwarded store data.
module writeback_commit_arbiter
  import taiga_types::*;
#(
  parameter int unsigned NUM_UNITS    = CFG_NUM_UNITS,
  parameter int unsigned COMMIT_PORTS = CFG_COMMIT_PORTS,
  parameter int unsigned READ_PORTS   = CFG_READ_PORTS,
  parameter int unsigned XLEN         = CFG_XLEN,
  parameter int unsigned ID_W         = CFG_ID_W,
  localparam int unsigned BANK_W      = $clog2(COMMIT_PORTS),
  localparam int unsigned UW          = $clog2(NUM_UNITS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 alu_issued,
  input  logic [NUM_UNITS-1:0]                 unit_done,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]       unit_id,
  input  logic [NUM_UNITS-1:0][XLEN-1:0]       unit_data,
  output logic [NUM_UNITS-1:0]                 unit_ack,
  output logic [COMMIT_PORTS-1:0]              commit_valid,
  output logic [COMMIT_PORTS-1:0][ID_W-1:0]    commit_id,
  output logic [COMMIT_PORTS-1:0][XLEN-1:0]    commit_data,
  input  logic [COMMIT_PORTS-1:0][4:0]         rd_addr,
  input  logic [COMMIT_PORTS-1:0][ID_W-1:0]    id_for_rd,
  output logic [COMMIT_PORTS-1:0]              commit_we,
  input  logic [READ_PORTS-1:0][4:0]           rs_addr,
  output logic [READ_PORTS-1:0][BANK_W-1:0]    rs_bank_sel,
  input  logic                                 store_waiting,
  input  logic [ID_W-1:0]                      store_id_needed,
  input  logic                                 store_ack,
  output logic                                 store_id_done,
  output logic [XLEN-1:0]                      store_data
);

  localparam int unsigned SW = UW + 1;

  logic [UW-1:0]                    rr_ptr;
  logic [UW-1:0]                    rr_next;
  logic [UW-1:0]                    last_unit;
  logic [BANK_W-1:0]                grant_cnt;
  logic [COMMIT_PORTS-1:1]          grant_valid;
  logic [COMMIT_PORTS-1:1][UW-1:0]  grant_unit;
  logic [SW-1:0]                    scan_sum;
  logic [UW-1:0]                    scan_u;
  logic                             any_grant;
  commit_packet_t [COMMIT_PORTS-1:0] pkt;
  logic                             fwd_hit;
  logic [XLEN-1:0]                  fwd_data;
  logic                             unused_port0_id;

  // The ALU always owns port 0, so its ID-table entry is never consulted.
  assign unused_port0_id = ^id_for_rd[0];

  // Rotating scan over units 1..NUM_UNITS-1 starting at rr_ptr; k-th hit goes to port k.
  always_comb begin
    grant_valid = '0;
    grant_unit  = '0;
    grant_cnt   = '0;
    last_unit   = rr_ptr;
    scan_sum    = '0;
    scan_u      = '0;
    unit_ack    = '0;
    for (int unsigned o = 0; o < NUM_UNITS - 1; o++) begin
      scan_sum = SW'(rr_ptr) + SW'(o);
      if (scan_sum >= SW'(NUM_UNITS)) scan_sum = scan_sum - SW'(NUM_UNITS - 1);
      scan_u = UW'(scan_sum);
      if (unit_done[scan_u] && (grant_cnt < BANK_W'(COMMIT_PORTS - 1))) begin
        grant_cnt              = grant_cnt + BANK_W'(1);
        grant_valid[grant_cnt] = 1'b1;
        grant_unit[grant_cnt]  = scan_u;
        unit_ack[scan_u]       = 1'b1;
        last_unit              = scan_u;
      end
    end
    unit_ack[0] = alu_issued;
  end

  assign any_grant = |grant_valid;
  assign rr_next   = (last_unit == UW'(NUM_UNITS - 1)) ? UW'(1) : last_unit + UW'(1);

  always_ff @(posedge clk) begin
    if (rst)            rr_ptr <= UW'(1);
    else if (any_grant) rr_ptr <= rr_next;
  end

  // Build per-port commit packets; ungranted ports stay all-zero.
  always_comb begin
    pkt          = '0;
    pkt[0].valid = alu_issued;
    pkt[0].id    = unit_id[0];
    pkt[0].data  = unit_data[0];
    for (int unsigned k = 1; k < COMMIT_PORTS; k++) begin
      if (grant_valid[k]) begin
        pkt[k].valid = 1'b1;
        pkt[k].id    = unit_id[grant_unit[k]];
        pkt[k].data  = unit_data[grant_unit[k]];
      end
    end
    commit_valid = '0;
    commit_id    = '0;
    commit_data  = '0;
    for (int unsigned k = 0; k < COMMIT_PORTS; k++) begin
      commit_valid[k] = pkt[k].valid;
      commit_id[k]    = pkt[k].id;
      commit_data[k]  = pkt[k].data;
    end
  end

  // Lower port wins a same-register race so the LVT sees at most one writer per entry.
  always_comb begin
    commit_we    = '0;
    commit_we[0] = alu_issued && (rd_addr[0] != 5'd0);
    for (int unsigned i = 1; i < COMMIT_PORTS; i++) begin
      commit_we[i] = commit_valid[i] && (id_for_rd[i] == commit_id[i]) && (rd_addr[i] != 5'd0);
      for (int unsigned j = 0; j < i; j++) begin
        if (commit_we[j] && (rd_addr[j] == rd_addr[i])) commit_we[i] = 1'b0;
      end
    end
  end

  commit_lvt #(
    .WRITE_PORTS (COMMIT_PORTS),
    .READ_PORTS  (READ_PORTS)
  ) u_lvt (
    .clk   (clk),
    .rst   (rst),
    .we    (commit_we),
    .waddr (rd_addr),
    .raddr (rs_addr),
    .rdata (rs_bank_sel)
  );

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 1; i < COMMIT_PORTS; i++) begin
      if (!fwd_hit && store_waiting && commit_valid[i] && (commit_id[i] == store_id_needed)) begin
        fwd_hit  = 1'b1;
        fwd_data = commit_data[i];
      end
    end
  end

  // A new match takes precedence over an ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_id_done <= 1'b0;
      store_data    <= '0;
    end else if (fwd_hit) begin
      store_id_done <= 1'b1;
      store_data    <= fwd_data;
    end else if (store_ack) begin
      store_id_done <= 1'b0;
    end
  end

endmodule

// File: doc/writeback_commit_arbiter.md
# writeback_commit_arbiter

Parametrised writeback arbiter that sits between the execution units and the multi-bank register file. It assigns completing units to commit ports using rotating priority, so no unit can starve. It maintains the live-value table (LVT) that selects which bank each source read comes from. It also captures forwarded store data behind a registered done/ack handshake.

## Interface
- NUM_UNITS, 5: writeback units. Unit 0 is the single-cycle ALU.
- COMMIT_PORTS, 3: commit ports / register-file banks. Must be ≥2 and ≤NUM_UNITS.
- READ_PORTS, 2: source read ports.
- XLEN, 32: data width.
- ID_W, 3: instruction ID width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_issued  in  1  ALU result valid this cycle (port 0)
- unit_done  in  [NUM_UNITS]  unit has a result pending
- unit_id  in  [NUM_UNITS][ID_W]  ID of the pending result
- unit_data  in  [NUM_UNITS][XLEN]  result data
- unit_ack  out  [NUM_UNITS]  result accepted this cycle
- commit_valid  out  [COMMIT_PORTS]  port retiring this cycle
- commit_id  out  [COMMIT_PORTS][ID_W]  retiring ID per port
- commit_data  out  [COMMIT_PORTS][XLEN]  retiring data per port
- rd_addr  in  [COMMIT_PORTS][5]  destination register of commit_id, from the external ID table
- id_for_rd  in  [COMMIT_PORTS][ID_W]  newest ID issued to rd_addr
- commit_we  out  [COMMIT_PORTS]  bank write enable
- rs_addr  in  [READ_PORTS][5]  source addresses
- rs_bank_sel  out  [READ_PORTS][$clog2(COMMIT_PORTS)]  bank holding the live value
- store_waiting  in  1  store is waiting on a forwarded ID
- store_id_needed  in  ID_W  ID the store needs
- store_ack  in  1  store consumed the forwarded data
- store_id_done  out  1  forwarded data valid
- store_data  out  XLEN  forwarded data

## Operation
**Port 0**
- Dedicated to unit 0.
- commit_valid[0] = unit_ack[0] = alu_issued.
- commit_id[0] and commit_data[0] come from unit 0.

**Ports 1..COMMIT_PORTS-1**
- Rotating-priority scan over units 1..NUM_UNITS-1, starting at rr_ptr and wrapping back to 1.
- The k-th done unit found is assigned to port k; at most COMMIT_PORTS-1 grants per cycle.
- Granted units get unit_ack=1. Ungranted done units hold their result.
- Ungranted ports: commit_valid=0, commit_id=0, commit_data=0.

**rr_ptr**
- Range 1..NUM_UNITS-1; reset value 1.
- Updates only when at least one port≥1 grants.
- New value is the unit after the last granted unit, wrapping from NUM_UNITS-1 to 1.

**commit_we**
- Port 0: commit_we[0] = alu_issued & (rd_addr[0]≠0).
- Port i≥1: commit_we[i] = commit_valid[i] & (id_for_rd[i]==commit_id[i]) & (rd_addr[i]≠0), AND no port j<i has commit_we[j] with the same rd_addr.

**LVT**
- 32 entries of $clog2(COMMIT_PORTS) bits; every entry resets to 0.
- At each clock edge, lvt[rd_addr[i]] is written with i for every port where commit_we[i]=1.
- By construction at most one port writes a given entry per cycle.
- rs_bank_sel[r] = lvt[rs_addr[r]], a combinational read with no same-cycle bypass.

**Store forwarding**
- A match is store_waiting & commit_valid[i] & commit_id[i]==store_id_needed, for some i≥1.
- On a match, store_data is loaded with that port's commit_data and store_id_done is set to 1.
- store_ack clears store_id_done.
- A match in the same cycle as store_ack wins: data loads and done stays 1.
- store_data holds its value while store_id_done=0.

## Timing
- Grants, unit_ack, commit_* and commit_we are combinational in the same cycle as unit_done / alu_issued.
- LVT and rr_ptr update at the edge after the commit. rs_bank_sel reflects a commit one cycle later.
- store_id_done rises one cycle after the match and falls one cycle after store_ack.
- Reset values: store_id_done=0, store_data=0, rr_ptr=1, all LVT entries 0.
- Reset asserted mid-operation discards any pending store forward and any held pointer state.
- Starvation bound: a done unit is acked within ceil((NUM_UNITS-1)/(COMMIT_PORTS-1)) cycles.

## Structure
- In taiga_types: id_t, LOG2_COMMIT_PORTS, WB_UNITS_WIDTH, and a commit_packet_t (valid, id, data).
- Sub-module commit_lvt holds the LVT: write ports = COMMIT_PORTS, read ports = READ_PORTS.
- The scan, rr_ptr and store logic live in the top module.

## Test plan
- **Rotation.** Units 1-4 all done continuously, COMMIT_PORTS=3. Required grants in order: {1,2}, {3,4}, {1,2}; rr_ptr sequence 1→3→1.
- **Wrap.** rr_ptr=4, units 4 and 1 done. Port 1 gets unit 4, port 2 gets unit 1; next rr_ptr=2.
- **Same-rd conflict.** ALU writes x5 while port 1 commits x5 with a matching id_for_rd. Required: commit_we[1]=0; next cycle rs_bank_sel for x5 is 0.
- **Stale ID.** Port 2 commits x7 with id 3 while id_for_rd=4. Required: commit_we=0 and the LVT is unchanged. Writes to x0 never set commit_we.
- **Store forward.** store_waiting, id_needed=2, unit 3 retires id 2 with data 0xDEADBEEF on port 1. Next cycle: store_id_done=1 and store_data=0xDEADBEEF. After store_ack: done=0 and data is held.
- **Reset mid-forward.** store_id_done=1, then rst. Required: done=0, data=0, rr_ptr=1, all LVT entries 0.
